// File: rtl/seq_pkg.sv
// Shared symbol codes, decoder state type and symbol legality helper for the
// five-state sequence generator / decoder family.
package seq_pkg;

   localparam logic [2:0] SYM_0 = 3'd0;
   localparam logic [2:0] SYM_2 = 3'd2;
   localparam logic [2:0] SYM_3 = 3'd3;
   localparam logic [2:0] SYM_4 = 3'd4;
   localparam logic [2:0] SYM_5 = 3'd5;

   typedef enum logic {HUNT, LOCKED} dec_state_t;

   function automatic logic sym_is_legal(input logic [2:0] s);
      return (s == SYM_0) || (s == SYM_2) || (s == SYM_3) ||
             (s == SYM_4) || (s == SYM_5);
   endfunction

endpackage

// File: rtl/seq_trans_check.sv
// Combinational transition checker for the generator graph: flags legal
// prev->sym pairs and recovers the generator input bit where it is observable.
module seq_trans_check
   import seq_pkg::*;
(
   input  logic [2:0] prev,
   input  logic [2:0] sym,
   output logic       legal,
   output logic       has_bit,
   output logic       bit_val
);

   always_comb begin
      legal   = 1'b0;
      has_bit = 1'b0;
      bit_val = 1'b0;
      case (prev)
         SYM_0: legal = (sym == SYM_3);
         SYM_2: legal = (sym == SYM_4);
         SYM_5: legal = (sym == SYM_2);
         // Only states 3 and 4 branch on a, so only they reveal it
         SYM_3: begin
            legal   = (sym == SYM_5) || (sym == SYM_2);
            has_bit = legal;
            bit_val = (sym == SYM_5);
         end
         SYM_4: begin
            legal   = (sym == SYM_3) || (sym == SYM_0);
            has_bit = legal;
            bit_val = (sym == SYM_3);
         end
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/seq_bit_decoder.sv
// Receive-side decoder for the sequence generator: hunts for sync, locks after
// a run of legal transitions, recovers input bits and tracks errors.
module seq_bit_decoder
   import seq_pkg::*;
#(
   parameter int LOCK_LEN = 2,
   parameter int MAX_ERR  = 3,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sym_valid,
   input  logic [2:0]       sym,
   output logic             bit_valid,
   output logic             bit_out,
   output logic             locked,
   output logic             err,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [3:0] LOCK_LEN_C = 4'(LOCK_LEN);
   localparam logic [3:0] MAX_ERR_C  = 4'(MAX_ERR);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) return v;
      return v + CNT_W'(1);
   endfunction

   dec_state_t       state_q, state_d;
   logic [2:0]       prev_q, prev_d;
   logic             prev_valid_q, prev_valid_d;
   logic [3:0]       run_q, run_d;
   logic [3:0]       err_run_q, err_run_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;
   logic             bit_valid_d, bit_out_d, err_d;
   logic             bit_out_q;
   logic             bit_valid_q, err_q;

   logic trans_legal, trans_has_bit, trans_bit;
   logic sym_ok;

   seq_trans_check u_check (
      .prev    (prev_q),
      .sym     (sym),
      .legal   (trans_legal),
      .has_bit (trans_has_bit),
      .bit_val (trans_bit)
   );

   assign sym_ok = sym_is_legal(sym);

   always_comb begin
      state_d      = state_q;
      prev_d       = prev_q;
      prev_valid_d = prev_valid_q;
      run_d        = run_q;
      err_run_d    = err_run_q;
      err_count_d  = err_count_q;
      bit_valid_d  = 1'b0;
      bit_out_d    = bit_out_q;
      err_d        = 1'b0;
      if (sym_valid) begin
         case (state_q)
            HUNT: begin
               if (!sym_ok) begin
                  // Invalid code leaves prev untouched but voids it as a seed
                  prev_valid_d = 1'b0;
                  run_d        = '0;
               end else if (!prev_valid_q) begin
                  prev_d       = sym;
                  prev_valid_d = 1'b1;
                  run_d        = '0;
               end else if (trans_legal) begin
                  prev_d = sym;
                  if (run_q + 4'd1 == LOCK_LEN_C) begin
                     state_d   = LOCKED;
                     run_d     = '0;
                     err_run_d = '0;
                  end else begin
                     run_d = run_q + 4'd1;
                  end
               end else begin
                  prev_d = sym;
                  run_d  = '0;
               end
            end
            LOCKED: begin
               if (trans_legal) begin
                  prev_d      = sym;
                  err_run_d   = '0;
                  bit_valid_d = trans_has_bit;
                  if (trans_has_bit) bit_out_d = trans_bit;
               end else begin
                  err_d       = 1'b1;
                  err_count_d = sat_inc(err_count_q);
                  if (sym_ok) prev_d = sym;
                  if (err_run_q + 4'd1 == MAX_ERR_C) begin
                     state_d      = HUNT;
                     prev_valid_d = sym_ok;
                     run_d        = '0;
                     err_run_d    = '0;
                  end else begin
                     err_run_d = err_run_q + 4'd1;
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= HUNT;
         prev_q       <= SYM_0;
         prev_valid_q <= 1'b0;
         run_q        <= '0;
         err_run_q    <= '0;
         err_count_q  <= '0;
         bit_valid_q  <= 1'b0;
         bit_out_q    <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_q       <= prev_d;
         prev_valid_q <= prev_valid_d;
         run_q        <= run_d;
         err_run_q    <= err_run_d;
         err_count_q  <= err_count_d;
         bit_valid_q  <= bit_valid_d;
         bit_out_q    <= bit_out_d;
         err_q        <= err_d;
      end
   end

   assign locked    = (state_q == LOCKED);
   assign bit_valid = bit_valid_q;
   assign bit_out   = bit_out_q;
   assign err       = err_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_seq_bit_decoder.sv
// Directed bench for seq_bit_decoder with a narrow error counter so that
// counter saturation is reachable in a few cycles.
module tb_seq_bit_decoder;

   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          sym_valid;
   logic [2:0]    sym;
   logic          bit_valid, bit_out, locked, err;
   logic [CW-1:0] err_count;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   seq_bit_decoder #(.LOCK_LEN(2), .MAX_ERR(3), .CNT_W(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .sym_valid (sym_valid),
      .sym       (sym),
      .bit_valid (bit_valid),
      .bit_out   (bit_out),
      .locked    (locked),
      .err       (err),
      .err_count (err_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic send(input logic v, input logic [2:0] s);
      sym_valid = v;
      sym       = s;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic lk, input logic bv,
                             input logic b, input logic e, input int cnt);
      chk({tag, "_locked"}, 32'(locked), 32'(lk));
      chk({tag, "_bit_valid"}, 32'(bit_valid), 32'(bv));
      if (bv) chk({tag, "_bit_out"}, 32'(bit_out), 32'(b));
      chk({tag, "_err"}, 32'(err), 32'(e));
      chk({tag, "_err_count"}, 32'(err_count), 32'(cnt));
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      sym_valid = 1'b0;
      sym       = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   function automatic logic [2:0] gen_next(input logic [2:0] s, input logic a);
      case (s)
         3'd0:    return 3'd3;
         3'd2:    return 3'd4;
         3'd5:    return 3'd2;
         3'd3:    return a ? 3'd5 : 3'd2;
         3'd4:    return a ? 3'd3 : 3'd0;
         default: return 3'd0;
      endcase
   endfunction

   logic [2:0] seq1   [8] = '{3'd0, 3'd3, 3'd2, 3'd4, 3'd0, 3'd3, 3'd5, 3'd2};
   logic       seq1_lk[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   logic       seq1_bv[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   logic       seq1_b [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      logic [2:0] cur, prev_s;
      logic       a, prev_a;

      do_reset();
      expect_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0);
      chk("reset_bit_out", 32'(bit_out), 32'd0);

      // Basic lock and recovery
      for (int i = 0; i < 8; i++) begin
         send(1'b1, seq1[i]);
         expect_out($sformatf("basic%0d", i), seq1_lk[i], seq1_bv[i], seq1_b[i], 1'b0, 0);
      end

      // Illegal transitions from prev=2: 2->5 then 5->4, then legal 4->3
      send(1'b1, 3'd5); expect_out("inj5",  1'b1, 1'b0, 1'b0, 1'b1, 1);
      send(1'b1, 3'd4); expect_out("inj4",  1'b1, 1'b0, 1'b0, 1'b1, 2);
      send(1'b1, 3'd3); expect_out("rec3",  1'b1, 1'b1, 1'b1, 1'b0, 2);

      // Three invalid codes drop lock; relock needs a fresh seed
      send(1'b1, 3'd7); expect_out("inv1",  1'b1, 1'b0, 1'b0, 1'b1, 3);
      send(1'b1, 3'd7); expect_out("inv2",  1'b1, 1'b0, 1'b0, 1'b1, 4);
      send(1'b1, 3'd7); expect_out("inv3",  1'b0, 1'b0, 1'b0, 1'b1, 5);
      send(1'b1, 3'd5); expect_out("seed",  1'b0, 1'b0, 1'b0, 1'b0, 5);
      send(1'b1, 3'd2); expect_out("run1",  1'b0, 1'b0, 1'b0, 1'b0, 5);
      send(1'b1, 3'd4); expect_out("relk",  1'b1, 1'b0, 1'b0, 1'b0, 5);
      send(1'b1, 3'd0); expect_out("rb0",   1'b1, 1'b1, 1'b0, 1'b0, 5);
      send(1'b1, 3'd3); expect_out("r3",    1'b1, 1'b0, 1'b0, 1'b0, 5);

      // Gap with sym_valid low between 3 and 5, garbage on sym
      for (int i = 0; i < 5; i++) begin
         send(1'b0, 3'd7);
         expect_out($sformatf("gap%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 5);
      end
      send(1'b1, 3'd5); expect_out("gap5",  1'b1, 1'b1, 1'b1, 1'b0, 5);

      // Error counter saturation at all-ones with lock held by interleaved legal symbols
      send(1'b1, 3'd7); expect_out("sat1",  1'b1, 1'b0, 1'b0, 1'b1, 6);
      send(1'b1, 3'd7); expect_out("sat2",  1'b1, 1'b0, 1'b0, 1'b1, 7);
      send(1'b1, 3'd2); expect_out("sat3",  1'b1, 1'b0, 1'b0, 1'b0, 7);
      send(1'b1, 3'd7); expect_out("sat4",  1'b1, 1'b0, 1'b0, 1'b1, 7);
      send(1'b1, 3'd7); expect_out("sat5",  1'b1, 1'b0, 1'b0, 1'b1, 7);
      send(1'b1, 3'd4); expect_out("sat6",  1'b1, 1'b0, 1'b0, 1'b0, 7);

      // Reset while locked overrides a symbol that would yield a bit (4->0)
      reset = 1'b1; sym_valid = 1'b1; sym = 3'd0;
      @(posedge clk); #1;
      reset = 1'b0; sym_valid = 1'b0;
      expect_out("mrst", 1'b0, 1'b0, 1'b0, 1'b0, 0);
      send(1'b1, 3'd3); expect_out("mrst_seed", 1'b0, 1'b0, 1'b0, 1'b0, 0);
      send(1'b1, 3'd5); expect_out("mrst_run",  1'b0, 1'b0, 1'b0, 1'b0, 0);

      // Generator-driven stream: a=0 x8, a=1 x16, a=0 x12, a=1 x4
      do_reset();
      cur = 3'd0; prev_s = 3'd0; prev_a = 1'b0;
      for (int i = 0; i < 40; i++) begin
         logic exp_bv;
         a = (i < 8) ? 1'b0 : (i < 24) ? 1'b1 : (i < 36) ? 1'b0 : 1'b1;
         exp_bv = (i >= 3) && (prev_s == 3'd3 || prev_s == 3'd4);
         send(1'b1, cur);
         expect_out($sformatf("gen%0d", i), (i >= 2), exp_bv, prev_a, 1'b0, 0);
         prev_s = cur;
         prev_a = a;
         cur    = gen_next(cur, a);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
